// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state encoding and sizing constants for the instruction-memory loader
package imem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int MEM_SIZE   = 40;

endpackage

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - assembles four accepted bytes little-endian into one 32-bit word
module imem_byte_packer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  output logic        o_word_complete,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_valid) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_idx                        <= r_idx + 2'd1;
    end
  end

  // The word including the byte accepted this cycle, so the top can capture it on the 4th handshake.
  always_comb begin
    o_word = r_word;
    if (i_valid) begin
      o_word[{r_idx, 3'b000} +: 8] = i_byte;
    end
  end

  assign o_word_complete = i_valid && (r_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader into instruction memory; optional IMEM_LOADER_CHECKSUM_EN adds a word-sum checksum
module imem_loader
  import imem_pkg::*;
#(
  parameter int MemSize = MEM_SIZE,
  parameter int CountW  = 16
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              Start,
  input  logic [63:0]       BaseAddress,
  input  logic [CountW-1:0] WordCount,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              WrEnable,
  output logic [63:0]       WrAddress,
  output logic [31:0]       WrData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error,
  output logic [31:0]       Checksum
);

  localparam logic [64:0] MEM_BYTES = 65'(MemSize * WORD_BYTES);

  state_e            r_state;
  state_e            w_next;
  logic [63:0]       r_ptr;
  logic [CountW-1:0] r_remaining;
  logic [63:0]       r_wr_addr;
  logic [31:0]       r_wr_data;

  logic [64:0] w_end;
  logic        w_start_bad;
  logic        w_can_start;
  logic        w_launch;
  logic        w_accept;
  logic        w_word_complete;
  logic [31:0] w_word;

  // 65-bit end address so a huge BaseAddress cannot wrap below the memory size.
  assign w_end       = {1'b0, BaseAddress} + {{(63 - CountW){1'b0}}, WordCount, 2'b00};
  assign w_start_bad = (BaseAddress[1:0] != 2'b00) || (w_end > MEM_BYTES);
  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_ERROR);
  assign w_launch    = w_can_start && Start && !w_start_bad;
  assign w_accept    = ByteValid && ByteReady;

  imem_byte_packer u_packer (
    .i_clk           (CLK),
    .i_rst_n         (Reset_L),
    .i_valid         (w_accept),
    .i_clear         (w_launch),
    .i_byte          (ByteIn),
    .o_word_complete (w_word_complete),
    .o_word          (w_word)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_ERROR: begin
        if (Start) begin
          if (w_start_bad)           w_next = ST_ERROR;
          else if (WordCount == '0)  w_next = ST_DONE;
          else                       w_next = ST_COLLECT;
        end
      end
      ST_COLLECT: if (w_word_complete) w_next = ST_WRITE;
      ST_WRITE:   w_next = (r_remaining == CountW'(1)) ? ST_DONE : ST_COLLECT;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 64'd0;
      r_remaining <= '0;
      r_wr_addr   <= 64'd0;
      r_wr_data   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_ptr       <= BaseAddress;
        r_remaining <= WordCount;
      end
      if (r_state == ST_COLLECT && w_word_complete) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_word;
      end
      if (r_state == ST_WRITE) begin
        r_ptr       <= r_ptr + 64'd4;
        r_remaining <= r_remaining - CountW'(1);
      end
    end
  end

  assign ByteReady = (r_state == ST_COLLECT);
  assign WrEnable  = (r_state == ST_WRITE);
  assign CpuHold   = (r_state == ST_COLLECT) || (r_state == ST_WRITE);
  assign Done      = (r_state == ST_DONE);
  assign Error     = (r_state == ST_ERROR);
  assign WrAddress = r_wr_addr;
  assign WrData    = r_wr_data;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge CLK) begin
    if (!Reset_L)                 r_sum <= 32'd0;
    else if (w_launch)            r_sum <= 32'd0;
    else if (r_state == ST_WRITE) r_sum <= r_sum + r_wr_data;
  end

  assign Checksum = r_sum;
`else
  assign Checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader: vector table, randomized loads and a mid-load reset
module tb_imem_loader;

  localparam int MEM_WORDS = 40;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        Start;
  logic [63:0] BaseAddress;
  logic [15:0] WordCount;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WrEnable;
  logic [63:0] WrAddress;
  logic [31:0] WrData;
  logic        CpuHold;
  logic        Done;
  logic        Error;
  logic [31:0] Checksum;

  int checks = 0;
  int errors = 0;

  imem_loader #(.MemSize(MEM_WORDS), .CountW(16)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Start(Start), .BaseAddress(BaseAddress),
    .WordCount(WordCount), .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .WrEnable(WrEnable), .WrAddress(WrAddress), .WrData(WrData), .CpuHold(CpuHold),
    .Done(Done), .Error(Error), .Checksum(Checksum)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] base;
    logic [15:0] count;
    int          mode;      // 0 always valid, 1 toggle, 2 random
    bit          fixed;
    logic [63:0] fbytes;    // byte k at [8k+7:8k]
    bit          exp_ok;
  } vec_t;

  // abort_after >= 0 returns once that many bytes have been accepted (used for the reset test)
  task automatic run_case(input logic [63:0] base, input logic [15:0] cnt, input int mode,
                          input bit fixed, input logic [63:0] fb, input bit exp_ok,
                          input int abort_after);
    logic [7:0]  bq[$];
    logic [31:0] wexp[$];
    logic [31:0] sum = 32'd0;
    int n = 1, consumed = 0, nw = 0, done_cnt = 0, done_n = -1;
    int hold_bad = 0, err_drop = 0, addr_bad = 0, data_bad = 0, early_wr = 0;
    bit br_seen = 0, err_seen = 0, timed_out = 0, want, hs;
    for (int i = 0; i < int'(cnt) * 4; i++) begin
      if (fixed && i < 8) bq.push_back(fb[8*i +: 8]);
      else                bq.push_back(8'($urandom));
    end
    for (int w = 0; w < int'(cnt); w++) begin
      wexp.push_back({bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]});
      sum = sum + wexp[w];
    end
    @(posedge CLK); #1;
    Start = 1'b1; BaseAddress = base; WordCount = cnt;
    @(posedge CLK); #1;
    Start = 1'b0; BaseAddress = $urandom; WordCount = 16'($urandom);
    forever begin
      if (n > 1200) begin timed_out = 1; break; end
      if (WrEnable) begin
        if (consumed != 4 * (nw + 1)) early_wr++;
        if (nw < wexp.size()) begin
          if (WrAddress !== base + 64'(4 * nw)) addr_bad++;
          if (WrData !== wexp[nw]) data_bad++;
        end
        nw++;
      end
      if (ByteReady) br_seen = 1;
      if (Error) err_seen = 1;
      else if (err_seen) err_drop++;
      if (Done) begin
        done_cnt++; done_n = n;
        if (CpuHold) hold_bad++;
        break;
      end
      if (exp_ok && cnt != 0 && !CpuHold) hold_bad++;
      if (!exp_ok && n >= 4) break;
      if (abort_after >= 0 && consumed == abort_after) begin
        ByteValid = 1'b0;
        return;
      end
      case (mode)
        0:       want = 1;
        1:       want = (n % 2) == 1;
        default: want = $urandom_range(0, 1) == 1;
      endcase
      ByteValid = want && (consumed < bq.size());
      ByteIn    = ByteValid ? bq[consumed] : 8'($urandom);
      hs        = ByteReady && ByteValid;
      @(posedge CLK); #1;
      if (hs) consumed++;
      n++;
    end
    ByteValid = 1'b0;
    chk("no_timeout", 64'(timed_out), 64'd0);
    if (exp_ok) begin
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("write_count", 64'(nw), 64'(cnt));
      chk("bytes_taken", 64'(consumed), 64'(int'(cnt) * 4));
      chk("write_addr_errs", 64'(addr_bad), 64'd0);
      chk("write_data_errs", 64'(data_bad), 64'd0);
      chk("write_before_4th_byte", 64'(early_wr), 64'd0);
      chk("cpuhold_errs", 64'(hold_bad), 64'd0);
      chk("error_during_ok", 64'(err_seen), 64'd0);
      if (cnt == 0) begin
        chk("zero_done_cycle", 64'(done_n), 64'd1);
        chk("zero_byteready", 64'(br_seen), 64'd0);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("checksum", 64'(Checksum), 64'(sum));
`else
      chk("checksum_tied0", 64'(Checksum), 64'd0);
`endif
    end else begin
      chk("error_flag", 64'(err_seen), 64'd1);
      chk("error_sticky", 64'(err_drop), 64'd0);
      chk("error_no_write", 64'(nw), 64'd0);
      chk("error_byteready", 64'(br_seen), 64'd0);
      chk("error_no_done", 64'(done_cnt), 64'd0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{64'h34, 16'd2, 0, 1, 64'h8A0A018C_AA0B01AA, 1});
    vecs.push_back('{64'h34, 16'd2, 1, 1, 64'h8A0A018C_AA0B01AA, 1});
    vecs.push_back('{64'h9C, 16'd1, 2, 0, 64'h0, 1});
    vecs.push_back('{64'h9C, 16'd2, 0, 0, 64'h0, 0});
    vecs.push_back('{64'h2,  16'd1, 0, 0, 64'h0, 0});
    vecs.push_back('{64'h0,  16'd0, 0, 0, 64'h0, 1});
    vecs.push_back('{64'h10, 16'd3, 2, 0, 64'h0, 1});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFC, 16'd2, 0, 0, 64'h0, 0});
    vecs.push_back('{64'h0,  16'd40, 2, 0, 64'h0, 1});
    vecs.push_back('{64'h0,  16'd2, 0, 1, 64'h00000002_FFFFFFFF, 1});
    vecs.push_back('{64'h4,  16'd39, 0, 0, 64'h0, 1});
    vecs.push_back('{64'h4,  16'd40, 0, 0, 64'h0, 0});

    Reset_L = 1'b0; Start = 1'b0; BaseAddress = '0; WordCount = '0;
    ByteIn = '0; ByteValid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs", {WrEnable, ByteReady, CpuHold, Done, Error, 59'd0} | 64'(WrAddress)
                         | 64'(WrData) | 64'(Checksum), 64'd0);
    Reset_L = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_case(vecs[i].base, vecs[i].count, vecs[i].mode, vecs[i].fixed,
               vecs[i].fbytes, vecs[i].exp_ok, -1);

    for (int r = 0; r < 8; r++) begin
      logic [63:0] b;
      logic [15:0] c;
      bit ok;
      b = 64'($urandom_range(0, 44) * 4);
      if ($urandom_range(0, 7) == 0) b = b + 64'($urandom_range(1, 3));
      c = 16'($urandom_range(0, 6));
      ok = (b[1:0] == 2'b00) && ({1'b0, b} + 65'(c) * 4 <= 65'(MEM_WORDS * 4));
      run_case(b, c, int'($urandom_range(0, 2)), 0, 64'h0, ok, -1);
    end

    run_case(64'h34, 16'd2, 0, 0, 64'h0, 1, 6);
    Reset_L = 1'b0;
    @(posedge CLK); #1;
    chk("midload_reset_ctrl", {59'd0, WrEnable, ByteReady, CpuHold, Done, Error}, 64'd0);
    chk("midload_reset_addr", WrAddress, 64'd0);
    chk("midload_reset_data", {WrData, Checksum}, 64'd0);
    Reset_L = 1'b1;
    run_case(64'h0, 16'd1, 0, 1, 64'h0000_0000_44332211, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
